// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper coil-drive pattern set.
// The pattern constants here are the same ones the controller drives.
package stepper_pkg;

    // Pattern vector layout: {A, B, C, D, INH1, INH2}
    localparam logic [5:0] PAT_PH0 = 6'b010111;
    localparam logic [5:0] PAT_PH1 = 6'b000101;
    localparam logic [5:0] PAT_PH2 = 6'b100111;
    localparam logic [5:0] PAT_PH3 = 6'b100010;
    localparam logic [5:0] PAT_PH4 = 6'b101011;
    localparam logic [5:0] PAT_PH5 = 6'b001001;
    localparam logic [5:0] PAT_PH6 = 6'b011011;
    localparam logic [5:0] PAT_PH7 = 6'b010010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } phase_dec_t;

    // Map a drive pattern to its phase index; anything off-table is illegal.
    function automatic phase_dec_t decode_pattern(input logic [5:0] pat);
        phase_dec_t d;
        d.legal = 1'b1;
        d.idx   = 3'd0;
        case (pat)
            PAT_PH0: d.idx = 3'd0;
            PAT_PH1: d.idx = 3'd1;
            PAT_PH2: d.idx = 3'd2;
            PAT_PH3: d.idx = 3'd3;
            PAT_PH4: d.idx = 3'd4;
            PAT_PH5: d.idx = 3'd5;
            PAT_PH6: d.idx = 3'd6;
            PAT_PH7: d.idx = 3'd7;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stepper_pattern_filter.sv
// Input register plus stability counter. accept_o is high on every cycle
// where the registered pattern has been seen STABLE times in a row.
module stepper_pattern_filter #(
    parameter int STABLE = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       clear_i,
    input  logic [5:0] pattern_i,
    output logic [5:0] pattern_o,
    output logic       accept_o
);

    localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

    logic [5:0]       pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive identical samples, saturating at STABLE-1.
    always_comb begin
        cnt_d = cnt_q;
        if (pattern_i != pat_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sample the pattern every cycle; clear only restarts the count.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            pat_q <= '0;
            cnt_q <= '0;
        end else begin
            pat_q <= pattern_i;
            cnt_q <= clear_i ? '0 : cnt_d;
        end
    end

    assign pattern_o = pat_q;
    assign accept_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/stepper_phase_decoder.sv
// Reconstructs stepper motion from the coil-drive lines: phase, direction,
// step mode and a signed half-step position, with illegal/skip detection.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not locked; first accepted legal pattern sets the phase
// ST_TRACK | locked; accepted patterns are converted into steps
// ST_FAULT | illegal pattern or skipped phase seen; frozen until clear
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int POS_W  = 16,   // must be at least 4
    parameter int STABLE = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    input  logic             d_i,
    input  logic             inh1_i,
    input  logic             inh2_i,
    output logic [POS_W-1:0] position_o,
    output logic [2:0]       phase_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             half_full_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    logic [5:0]       pattern;
    logic [5:0]       pat_s;
    logic             accept;
    phase_dec_t       dec;
    logic [2:0]       delta;
    logic [POS_W-1:0] step_amt;

    state_e           state_q;
    logic [POS_W-1:0] position_q;
    logic [2:0]       phase_q;
    logic             dir_q;
    logic             step_q;
    logic             half_q;
    logic             locked_q;
    logic             err_q;
    logic [1:0]       err_code_q;

    assign pattern = {a_i, b_i, c_i, d_i, inh1_i, inh2_i};

    stepper_pattern_filter #(
        .STABLE(STABLE)
    ) u_filter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (clear_i),
        .pattern_i(pattern),
        .pattern_o(pat_s),
        .accept_o (accept)
    );

    assign dec   = decode_pattern(pat_s);
    assign delta = dec.idx - phase_q;
    // Delta read as signed 3-bit gives +1, +2, -2, -1 for the legal steps.
    assign step_amt = {{(POS_W-3){delta[2]}}, delta};

    // Decoder FSM with all outputs registered; reset beats clear beats events.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            position_q <= '0;
            phase_q    <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            half_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (clear_i) begin
            state_q    <= ST_IDLE;
            position_q <= '0;
            step_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (dec.legal) begin
                            phase_q  <= dec.idx;
                            locked_q <= 1'b1;
                            state_q  <= ST_TRACK;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                            locked_q   <= 1'b0;
                            state_q    <= ST_FAULT;
                        end
                    end
                end
                ST_TRACK: begin
                    if (accept) begin
                        if (!dec.legal) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                            locked_q   <= 1'b0;
                            state_q    <= ST_FAULT;
                        end else begin
                            case (delta)
                                3'd0: ;
                                3'd1, 3'd2, 3'd6, 3'd7: begin
                                    position_q <= position_q + step_amt;
                                    dir_q      <= ~delta[2];
                                    half_q     <= delta[0];
                                    step_q     <= 1'b1;
                                    phase_q    <= dec.idx;
                                end
                                default: begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_SKIP;
                                    locked_q   <= 1'b0;
                                    state_q    <= ST_FAULT;
                                end
                            endcase
                        end
                    end
                end
                ST_FAULT: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign position_o  = position_q;
    assign phase_o     = phase_q;
    assign dir_o       = dir_q;
    assign step_o      = step_q;
    assign half_full_o = half_q;
    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder: a 16-bit and a 4-bit position
// instance share the same drive lines.
module tb_stepper_phase_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [5:0]  pat;

    logic [15:0] pos_w;
    logic [2:0]  phase_w;
    logic        dir_w, step_w, half_w, locked_w, err_w;
    logic [1:0]  code_w;

    logic [3:0]  pos_n;
    logic [2:0]  phase_n;
    logic        dir_n, step_n, half_n, locked_n, err_n;
    logic [1:0]  code_n;

    int checks = 0;
    int errors = 0;
    int steps  = 0;

    logic [5:0] ph_pat [8];

    always #5 clk = ~clk;

    stepper_phase_decoder #(.POS_W(16), .STABLE(2)) dut_w (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear),
        .a_i(pat[5]), .b_i(pat[4]), .c_i(pat[3]), .d_i(pat[2]),
        .inh1_i(pat[1]), .inh2_i(pat[0]),
        .position_o(pos_w), .phase_o(phase_w), .dir_o(dir_w), .step_o(step_w),
        .half_full_o(half_w), .locked_o(locked_w), .err_o(err_w), .err_code_o(code_w)
    );

    stepper_phase_decoder #(.POS_W(4), .STABLE(2)) dut_n (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear),
        .a_i(pat[5]), .b_i(pat[4]), .c_i(pat[3]), .d_i(pat[2]),
        .inh1_i(pat[1]), .inh2_i(pat[0]),
        .position_o(pos_n), .phase_o(phase_n), .dir_o(dir_n), .step_o(step_n),
        .half_full_o(half_n), .locked_o(locked_n), .err_o(err_n), .err_code_o(code_n)
    );

    // Drive a pattern for n edges, sampling 1 ns after each edge.
    task automatic hold(input logic [5:0] p, input int n);
        pat = p;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step_w) steps++;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pat = ph_pat[0];
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pos_w, phase_w, dir_w, step_w, half_w, locked_w, err_w, code_w} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0",
                     {pos_w, phase_w, dir_w, step_w, half_w, locked_w, err_w, code_w});
        end
        reset_n = 1'b1;
        steps = 0;
        hold(ph_pat[0], 4);
        checks++;
        if ({locked_w, phase_w, pos_w, err_w} !== {1'b1, 3'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL lock_ph0: got lk=%b ph=%0d pos=%h err=%b expected 1 0 0000 0",
                     locked_w, phase_w, pos_w, err_w);
        end
        checks++;
        if (steps !== 0) begin
            errors++;
            $display("FAIL lock_nostep: got %0d steps expected 0", steps);
        end
    endtask

    task automatic test_half_up();
        steps = 0;
        for (int i = 1; i <= 8; i++) hold(ph_pat[i % 8], 4);
        checks++;
        if (steps !== 8) begin
            errors++;
            $display("FAIL half_up_steps: got %0d expected 8", steps);
        end
        checks++;
        if ({dir_w, half_w, phase_w, pos_w} !== {1'b1, 1'b1, 3'd0, 16'd8}) begin
            errors++;
            $display("FAIL half_up_state: got dir=%b hf=%b ph=%0d pos=%h expected 1 1 0 0008",
                     dir_w, half_w, phase_w, pos_w);
        end
        checks++;
        if (pos_n !== 4'h8) begin
            errors++;
            $display("FAIL half_up_pos4: got %h expected 8", pos_n);
        end
    endtask

    task automatic test_full_down();
        pulse_clear();
        checks++;
        if ({pos_w, err_w, locked_w} !== {16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear_state: got pos=%h err=%b lk=%b expected 0000 0 0",
                     pos_w, err_w, locked_w);
        end
        hold(ph_pat[0], 4);
        steps = 0;
        hold(ph_pat[6], 4);
        hold(ph_pat[4], 4);
        hold(ph_pat[2], 4);
        hold(ph_pat[0], 4);
        checks++;
        if (steps !== 4) begin
            errors++;
            $display("FAIL full_dn_steps: got %0d expected 4", steps);
        end
        checks++;
        if ({dir_w, half_w, phase_w, pos_w} !== {1'b0, 1'b0, 3'd0, 16'hFFF8}) begin
            errors++;
            $display("FAIL full_dn_state: got dir=%b hf=%b ph=%0d pos=%h expected 0 0 0 fff8",
                     dir_w, half_w, phase_w, pos_w);
        end
        checks++;
        if (pos_n !== 4'h8) begin
            errors++;
            $display("FAIL full_dn_pos4: got %h expected 8", pos_n);
        end
    endtask

    task automatic test_glitch();
        pulse_clear();
        hold(ph_pat[0], 4);
        steps = 0;
        hold(6'b000000, 1);
        hold(ph_pat[1], 4);
        checks++;
        if ({steps[3:0], pos_w, err_w, phase_w} !== {4'd1, 16'd1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL glitch_low: got steps=%0d pos=%h err=%b ph=%0d expected 1 0001 0 1",
                     steps, pos_w, err_w, phase_w);
        end
        hold(ph_pat[0], 4);
        hold(6'b111111, 2);
        checks++;
        if (err_w !== 1'b0) begin
            errors++;
            $display("FAIL illegal_early: got err=%b expected 0", err_w);
        end
        hold(6'b111111, 1);
        checks++;
        if ({err_w, code_w, locked_w, phase_w, pos_w} !== {1'b1, 2'b01, 1'b0, 3'd0, 16'd0}) begin
            errors++;
            $display("FAIL illegal_fault: got err=%b code=%b lk=%b ph=%0d pos=%h expected 1 01 0 0 0000",
                     err_w, code_w, locked_w, phase_w, pos_w);
        end
    endtask

    task automatic test_skip();
        pulse_clear();
        hold(ph_pat[0], 4);
        hold(ph_pat[2], 4);
        hold(ph_pat[6], 4);
        checks++;
        if ({err_w, code_w, locked_w, phase_w, pos_w} !== {1'b1, 2'b10, 1'b0, 3'd2, 16'd2}) begin
            errors++;
            $display("FAIL skip_fault: got err=%b code=%b lk=%b ph=%0d pos=%h expected 1 10 0 2 0002",
                     err_w, code_w, locked_w, phase_w, pos_w);
        end
        steps = 0;
        hold(ph_pat[3], 4);
        checks++;
        if ({err_w, code_w, phase_w, pos_w, steps[3:0]} !== {1'b1, 2'b10, 3'd2, 16'd2, 4'd0}) begin
            errors++;
            $display("FAIL fault_hold: got err=%b code=%b ph=%0d pos=%h steps=%0d expected 1 10 2 0002 0",
                     err_w, code_w, phase_w, pos_w, steps);
        end
        pulse_clear();
        checks++;
        if ({err_w, code_w, pos_w, locked_w, phase_w} !== {1'b0, 2'b00, 16'd0, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL skip_clear: got err=%b code=%b pos=%h lk=%b ph=%0d expected 0 00 0000 0 2",
                     err_w, code_w, pos_w, locked_w, phase_w);
        end
        hold(ph_pat[3], 4);
        checks++;
        if ({locked_w, phase_w, pos_w, steps[3:0]} !== {1'b1, 3'd3, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL relock: got lk=%b ph=%0d pos=%h steps=%0d expected 1 3 0000 0",
                     locked_w, phase_w, pos_w, steps);
        end
    endtask

    task automatic test_back_to_back();
        steps = 0;
        hold(ph_pat[4], 2);
        hold(ph_pat[5], 2);
        hold(ph_pat[6], 2);
        hold(ph_pat[7], 3);
        checks++;
        if ({steps[3:0], pos_w, phase_w, dir_w, half_w} !== {4'd4, 16'd4, 3'd7, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back: got steps=%0d pos=%h ph=%0d dir=%b hf=%b expected 4 0004 7 1 1",
                     steps, pos_w, phase_w, dir_w, half_w);
        end
    endtask

    task automatic test_wrap_reset();
        pulse_clear();
        hold(ph_pat[0], 4);
        steps = 0;
        for (int i = 1; i <= 9; i++) hold(ph_pat[i % 8], 4);
        checks++;
        if ({pos_n, pos_w, steps[3:0], phase_n} !== {4'b1001, 16'd9, 4'd9, 3'd1}) begin
            errors++;
            $display("FAIL wrap4: got pos4=%b pos16=%h steps=%0d ph=%0d expected 1001 0009 9 1",
                     pos_n, pos_w, steps, phase_n);
        end
        pat = ph_pat[2];
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({pos_w, phase_w, dir_w, step_w, half_w, locked_w, err_w, code_w} !== 26'd0) begin
            errors++;
            $display("FAIL midreset_w: got %h expected 0",
                     {pos_w, phase_w, dir_w, step_w, half_w, locked_w, err_w, code_w});
        end
        checks++;
        if ({pos_n, phase_n, dir_n, step_n, half_n, locked_n, err_n, code_n} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_n: got %h expected 0",
                     {pos_n, phase_n, dir_n, step_n, half_n, locked_n, err_n, code_n});
        end
        hold(ph_pat[2], 4);
        checks++;
        if ({locked_n, phase_n, pos_n} !== {1'b1, 3'd2, 4'd0}) begin
            errors++;
            $display("FAIL post_reset_lock: got lk=%b ph=%0d pos=%h expected 1 2 0",
                     locked_n, phase_n, pos_n);
        end
    endtask

    initial begin
        ph_pat[0] = 6'b010111;
        ph_pat[1] = 6'b000101;
        ph_pat[2] = 6'b100111;
        ph_pat[3] = 6'b100010;
        ph_pat[4] = 6'b101011;
        ph_pat[5] = 6'b001001;
        ph_pat[6] = 6'b011011;
        ph_pat[7] = 6'b010010;
        reset_n = 1'b0;
        clear   = 1'b0;
        pat     = 6'b010111;
        test_reset();
        test_half_up();
        test_full_down();
        test_glitch();
        test_skip();
        test_back_to_back();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
